// File: rtl/adxl345_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_pkg
// Brief    : ADXL345 register map, reset values and responder FSM encoding.
// Revision : 1.0
// ============================================================================
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] RST_BW_RATE      = 8'h0A;
    localparam logic [7:0] RST_POWER_CTL    = 8'h00;
    localparam logic [7:0] RST_DATA_FORMAT  = 8'h00;
    localparam logic [7:0] RST_DATA         = 8'h00;

    localparam logic [1:0] ST_IDLE          = 2'd0;
    localparam logic [1:0] ST_CMD           = 2'd1;
    localparam logic [1:0] ST_DATA          = 2'd2;
    localparam logic [1:0] ST_WAIT_CS       = 2'd3;

endpackage
`default_nettype wire

// File: rtl/adxl345_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_spi_responder_if
// Brief    : 4-wire SPI bus (mode 3) plus MISO output-enable.
// Revision : 1.0
// ============================================================================
interface adxl345_spi_responder_if;
    logic CS;
    logic spi_clk;
    logic MOSI;
    logic MISO;
    logic miso_oe;

    modport master (output CS, spi_clk, MOSI, input MISO, miso_oe);
    modport slave  (input CS, spi_clk, MOSI, output MISO, miso_oe);
endinterface
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_edge_sync
// Brief    : Synchronizes CS/spi_clk/MOSI into clk and emits edge pulses.
// Revision : 1.0
// ============================================================================
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic cs_high,
    output logic cs_rise,
    output logic cs_fall,
    output logic sck_rise,
    output logic sck_fall,
    output logic mosi_bit
);
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_last;
    logic                   r_sck_last;
    logic                   w_sck;

    // Deliberately unreset: the chain keeps tracking the pins during reset so
    // the FSM sees the true CS level the moment reset releases.
    always_ff @(posedge clk) begin
        r_cs_sync[0]   <= cs_n;
        r_sck_sync[0]  <= sck;
        r_mosi_sync[0] <= mosi;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_sck_sync[i]  <= r_sck_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
        end
        r_cs_last  <= r_cs_sync[SYNC_STAGES-1];
        r_sck_last <= r_sck_sync[SYNC_STAGES-1];
    end

    assign cs_high  = r_cs_sync[SYNC_STAGES-1];
    assign cs_rise  = cs_high & ~r_cs_last;
    assign cs_fall  = ~cs_high & r_cs_last;
    assign w_sck    = r_sck_sync[SYNC_STAGES-1];
    assign sck_rise = w_sck & ~r_sck_last & ~cs_high;
    assign sck_fall = ~w_sck & r_sck_last & ~cs_high;
    assign mosi_bit = r_mosi_sync[SYNC_STAGES-1];
endmodule
`default_nettype wire

// File: rtl/adxl345_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adxl345_spi_responder
// Brief    : SPI mode-3 slave emulating the ADXL345 register interface.
// Revision : 1.0
// ============================================================================
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    adxl345_spi_responder_if.slave        spi,
    input  logic [15:0]                   x_data,
    input  logic [15:0]                   y_data,
    input  logic [15:0]                   z_data,
    input  logic                          sample_valid,
    output logic [7:0]                    bw_rate,
    output logic [7:0]                    power_ctl,
    output logic [7:0]                    data_format,
    output logic                          xfer_done
);
    logic       w_cs_high, w_cs_rise, w_cs_fall, w_sck_rise, w_sck_fall, w_mosi;
    logic [7:0] w_rx_byte;
    logic [5:0] w_next_addr;

    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic [5:0] r_addr;
    logic       r_rw, r_mb, r_byte_seen;
    logic       r_miso, r_miso_oe, r_xfer_done;
    logic [7:0] r_bw_rate, r_power_ctl, r_data_format;
    logic [7:0] r_data [6];
    logic [15:0] r_pend_x, r_pend_y, r_pend_z;
    logic       r_pend_valid;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .cs_n     (spi.CS),
        .sck      (spi.spi_clk),
        .mosi     (spi.MOSI),
        .cs_high  (w_cs_high),
        .cs_rise  (w_cs_rise),
        .cs_fall  (w_cs_fall),
        .sck_rise (w_sck_rise),
        .sck_fall (w_sck_fall),
        .mosi_bit (w_mosi)
    );

    assign w_rx_byte   = {r_rx_shift, w_mosi};
    assign w_next_addr = r_mb ? r_addr + 6'd1 : r_addr;

    function automatic logic [7:0] reg_read(input logic [5:0] a);
        case (a)
            ADDR_DEVID:       return DEVID_VAL;
            ADDR_BW_RATE:     return r_bw_rate;
            ADDR_POWER_CTL:   return r_power_ctl;
            ADDR_DATA_FORMAT: return r_data_format;
            ADDR_DATAX0:      return r_data[0];
            ADDR_DATAX1:      return r_data[1];
            ADDR_DATAY0:      return r_data[2];
            ADDR_DATAY1:      return r_data[3];
            ADDR_DATAZ0:      return r_data[4];
            ADDR_DATAZ1:      return r_data[5];
            default:          return 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 7'd0;
            r_tx_shift    <= 8'h00;
            r_addr        <= 6'd0;
            r_rw          <= 1'b0;
            r_mb          <= 1'b0;
            r_byte_seen   <= 1'b0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_xfer_done   <= 1'b0;
            r_bw_rate     <= RST_BW_RATE;
            r_power_ctl   <= RST_POWER_CTL;
            r_data_format <= RST_DATA_FORMAT;
            for (int i = 0; i < 6; i++) r_data[i] <= RST_DATA;
            r_pend_x      <= 16'h0000;
            r_pend_y      <= 16'h0000;
            r_pend_z      <= 16'h0000;
            r_pend_valid  <= 1'b0;
        end else begin
            r_xfer_done <= 1'b0;

            // A held sample lands at CS rise; a same-cycle strobe overrides it.
            if (w_cs_rise && r_pend_valid) begin
                r_data[0] <= r_pend_x[7:0];  r_data[1] <= r_pend_x[15:8];
                r_data[2] <= r_pend_y[7:0];  r_data[3] <= r_pend_y[15:8];
                r_data[4] <= r_pend_z[7:0];  r_data[5] <= r_pend_z[15:8];
                r_pend_valid <= 1'b0;
            end
            if (sample_valid) begin
                if (w_cs_high) begin
                    r_data[0] <= x_data[7:0];  r_data[1] <= x_data[15:8];
                    r_data[2] <= y_data[7:0];  r_data[3] <= y_data[15:8];
                    r_data[4] <= z_data[7:0];  r_data[5] <= z_data[15:8];
                end else begin
                    r_pend_x     <= x_data;
                    r_pend_y     <= y_data;
                    r_pend_z     <= z_data;
                    r_pend_valid <= 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) begin
                        r_state     <= ST_CMD;
                        r_bit_cnt   <= 3'd0;
                        r_byte_seen <= 1'b0;
                    end else if (!w_cs_high) begin
                        r_state <= ST_WAIT_CS;
                    end
                end
                ST_CMD, ST_DATA: begin
                    if (w_cs_high) begin
                        r_state     <= ST_IDLE;
                        r_miso_oe   <= 1'b0;
                        r_miso      <= 1'b0;
                        r_xfer_done <= r_byte_seen;
                    end else if (w_sck_rise) begin
                        r_rx_shift <= w_rx_byte[6:0];
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_byte_seen <= 1'b1;
                            if (r_state == ST_CMD) begin
                                r_rw    <= w_rx_byte[7];
                                r_mb    <= w_rx_byte[6];
                                r_addr  <= w_rx_byte[5:0];
                                r_state <= ST_DATA;
                                if (w_rx_byte[7]) begin
                                    r_tx_shift <= reg_read(w_rx_byte[5:0]);
                                    r_miso_oe  <= 1'b1;
                                end
                            end else begin
                                if (r_rw) begin
                                    r_tx_shift <= reg_read(w_next_addr);
                                end else begin
                                    case (r_addr)
                                        ADDR_BW_RATE:     r_bw_rate     <= w_rx_byte;
                                        ADDR_POWER_CTL:   r_power_ctl   <= w_rx_byte;
                                        ADDR_DATA_FORMAT: r_data_format <= w_rx_byte;
                                        default: ;
                                    endcase
                                end
                                r_addr <= w_next_addr;
                            end
                        end
                    end else if (w_sck_fall && r_state == ST_DATA && r_rw) begin
                        r_miso     <= r_tx_shift[7];
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
                ST_WAIT_CS: begin
                    if (w_cs_high) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign spi.MISO    = r_miso;
    assign spi.miso_oe = r_miso_oe;
    assign bw_rate     = r_bw_rate;
    assign power_ctl   = r_power_ctl;
    assign data_format = r_data_format;
    assign xfer_done   = r_xfer_done;
endmodule
`default_nettype wire

// File: tb/tb_adxl345_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adxl345_spi_responder
// Brief    : Directed bench for the ADXL345 SPI responder with a read scoreboard.
// Revision : 1.0
// ============================================================================
module tb_adxl345_spi_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] x_data, y_data, z_data;
    logic        sample_valid;
    logic [7:0]  bw_rate, power_ctl, data_format;
    logic        xfer_done;
    logic [7:0]  rx, oe;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;
    int done_exp = 0;
    logic [7:0] exp_q[$];

    adxl345_spi_responder_if spi();

    adxl345_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .x_data       (x_data),
        .y_data       (y_data),
        .z_data       (z_data),
        .sample_valid (sample_valid),
        .bw_rate      (bw_rate),
        .power_ctl    (power_ctl),
        .data_format  (data_format),
        .xfer_done    (xfer_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (xfer_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Mode 3: drive MOSI on the falling edge, sample MISO at the rising edge.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] r, output logic [7:0] o);
        r = 8'h00;
        o = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi.spi_clk = 1'b0;
            spi.MOSI    = tx[i];
            repeat (4) @(negedge clk);
            r[i] = spi.MISO;
            o[i] = spi.miso_oe;
            spi.spi_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic cs_low();
        spi.CS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        spi.CS = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        x_data = x;
        y_data = y;
        z_data = z;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic read_txn(input logic [7:0] cmd, input int n, input int strobe_at);
        logic [7:0] expv;
        cs_low();
        spi_bits(cmd, 8, rx, oe);
        check("oe_during_cmd", oe, 8'h00);
        for (int k = 0; k < n; k++) begin
            if (k == strobe_at) strobe(16'hAAAA, 16'h1357, 16'h8001);
            spi_bits(8'h00, 8, rx, oe);
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            check("read_byte", rx, expv);
            check("oe_during_data", oe, 8'hFF);
        end
        cs_high();
        done_exp++;
        check("oe_after_cs", spi.miso_oe, 1'b0);
        check("xfer_done_rd", done_cnt, done_exp);
    endtask

    task automatic write_txn(input logic [7:0] cmd, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
        cs_low();
        spi_bits(cmd, 8, rx, oe);
        spi_bits(d0, 8, rx, oe);
        check("oe_during_write", oe, 8'h00);
        if (n > 1) spi_bits(d1, 8, rx, oe);
        cs_high();
        done_exp++;
        check("xfer_done_wr", done_cnt, done_exp);
    endtask

    initial begin
        reset = 1'b1;
        spi.CS = 1'b1;
        spi.spi_clk = 1'b1;
        spi.MOSI = 1'b0;
        sample_valid = 1'b0;
        x_data = '0;
        y_data = '0;
        z_data = '0;
        repeat (10) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        check("rst_bw_rate", bw_rate, 8'h0A);
        check("rst_power_ctl", power_ctl, 8'h00);
        check("rst_data_format", data_format, 8'h00);
        check("rst_xfer_done", xfer_done, 1'b0);
        check("rst_miso_oe", spi.miso_oe, 1'b0);
        check("rst_miso", spi.MISO, 1'b0);

        // DEVID read
        exp_q.push_back(8'hE5);
        read_txn(8'h80, 1, -1);

        // power_ctl write then read back
        write_txn(8'h2D, 8'h08, 8'h00, 1);
        check("power_ctl_wr", power_ctl, 8'h08);
        exp_q.push_back(8'h08);
        read_txn(8'hAD, 1, -1);

        // Burst read with a mid-burst strobe that must not disturb it
        strobe(16'h1234, 16'hFFF0, 16'h0100);
        repeat (2) @(negedge clk);
        foreach (exp_q[i]) ;
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        read_txn(8'hF2, 6, 2);
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
        exp_q.push_back(8'h57); exp_q.push_back(8'h13);
        exp_q.push_back(8'h01); exp_q.push_back(8'h80);
        read_txn(8'hF2, 6, -1);

        // MB=0 keeps the address; MB=1 wraps 0x3F -> 0x00; unmapped reads 0
        exp_q.push_back(8'h80); exp_q.push_back(8'h80);
        read_txn(8'hB7, 2, -1);
        exp_q.push_back(8'h00); exp_q.push_back(8'hE5);
        read_txn(8'hFF, 2, -1);
        exp_q.push_back(8'h00);
        read_txn(8'h90, 1, -1);

        // Abort after 5 data bits: command byte completed, partial data dropped
        cs_low();
        spi_bits(8'h31, 8, rx, oe);
        spi_bits(8'hFF, 5, rx, oe);
        cs_high();
        done_exp++;
        check("abort_data_format", data_format, 8'h00);
        check("abort_xfer_done", done_cnt, done_exp);

        // Abort inside the command byte: no complete byte, no pulse
        cs_low();
        spi_bits(8'h31, 5, rx, oe);
        cs_high();
        check("abort_cmd_xfer_done", done_cnt, done_exp);

        // DEVID is read-only
        write_txn(8'h00, 8'h55, 8'h00, 1);
        exp_q.push_back(8'hE5);
        read_txn(8'h80, 1, -1);

        // Multi-byte write across 0x2C/0x2D, then data_format
        write_txn(8'h6C, 8'h0F, 8'h09, 2);
        check("mb_bw_rate", bw_rate, 8'h0F);
        check("mb_power_ctl", power_ctl, 8'h09);
        write_txn(8'h31, 8'h0B, 8'h00, 1);
        exp_q.push_back(8'h0B);
        read_txn(8'hB1, 1, -1);

        // Reset in the middle of a burst while CS stays low
        cs_low();
        spi_bits(8'hF2, 8, rx, oe);
        spi_bits(8'h00, 8, rx, oe);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        spi_bits(8'h2D, 8, rx, oe);
        check("post_rst_oe_cmd", oe, 8'h00);
        spi_bits(8'h77, 8, rx, oe);
        check("post_rst_oe_data", oe, 8'h00);
        check("post_rst_miso", rx, 8'h00);
        check("post_rst_power_ctl", power_ctl, 8'h00);
        check("post_rst_bw_rate", bw_rate, 8'h0A);
        check("post_rst_data_format", data_format, 8'h00);
        cs_high();
        check("post_rst_xfer_done", done_cnt, done_exp);
        repeat (6) exp_q.push_back(8'h00);
        read_txn(8'hF2, 6, -1);
        write_txn(8'h2D, 8'h77, 8'h00, 1);
        check("post_rst_write", power_ctl, 8'h77);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/adxl345_spi_responder.md
Name: adxl345_spi_responder

Overview:
- Synthesizable SPI slave that emulates the ADXL345 register interface: the responder end of the accelerometer SPI master's bus.
- Used on-chip or in simulation to exercise the master's configuration writes and X/Y/Z burst reads without the physical sensor.
- Sits on the CS/spi_clk/MOSI/MISO nets; axis sample words are supplied from a stimulus source or pattern generator.

Parameters:
- DEVID_VAL, 8'hE5, value returned at address 0x00.
- SYNC_STAGES, 2, synchronizer depth for CS, spi_clk and MOSI.

Ports:
- clk  input  1  system clock; spi_clk must be at most clk/8.
- reset  input  1  synchronous, active-high reset.
- CS  input  1  chip select, active low.
- spi_clk  input  1  SPI clock, mode 3 (CPOL=1, CPHA=1).
- MOSI  input  1  master-to-slave data, MSB first.
- MISO  output  1  slave-to-master data.
- miso_oe  output  1  high while MISO is driven (CS low after the command byte of a read).
- x_data, y_data, z_data  input  16 each  next axis sample, two's complement.
- sample_valid  input  1  one-cycle strobe that loads x/y/z_data.
- bw_rate  output  8  register 0x2C.
- power_ctl  output  8  register 0x2D.
- data_format  output  8  register 0x31.
- xfer_done  output  1  one-cycle pulse on CS rising edge after at least one complete byte.

Behaviour:
- Reset values: MISO=0, miso_oe=0, bw_rate=0x0A, power_ctl=0x00, data_format=0x00, xfer_done=0, data registers 0x32-0x37 = 0x00, state=IDLE.
- Inputs pass through a SYNC_STAGES flop synchronizer. Rising and falling edges of spi_clk are detected in clk domain; edges count only while synchronized CS is low.
- Mode 3: MOSI is sampled on the detected spi_clk rising edge. MISO is updated on the detected falling edge.
- The internal response lag is SYNC_STAGES+1 clk cycles. This meets timing because spi_clk is at most clk/8.
- First byte is the command: bit7 = R/nW, bit6 = MB (multi-byte), bits5:0 = address.
- States:
  - IDLE: wait for CS falling edge, then go to CMD.
  - CMD: shift 8 bits. On the 8th rising edge, latch address/RW/MB and go to DATA. For a read, load the tx shifter with reg[addr] and set miso_oe.
  - DATA: shift 8 bits per byte.
    - Write: on the 8th rising edge, write the byte to reg[addr].
    - Read: on the 8th rising edge, load reg[next addr] into the tx shifter.
    - If MB=1, addr increments after each byte and wraps 0x3F->0x00. If MB=0, addr stays fixed.
  - WAIT_CS: entered after reset release if CS is low. Ignores all edges until CS goes high, then returns to IDLE.
- MISO is driven on the falling edge that follows the 8th rising edge of the command. The first data bit is therefore valid before the first rising edge of the data byte.
- Register map:
  - 0x00: DEVID, read-only.
  - 0x2C, 0x2D, 0x31: read/write.
  - 0x32-0x37: DATAX0, X1, Y0, Y1, Z0, Z1, read-only, low byte at the even address.
  - All other addresses read 0x00; writes to them are ignored.
- Writes to read-only registers are ignored.
- sample_valid handling:
  - While CS is high, sample_valid updates 0x32-0x37 on the next cycle.
  - While CS is low, the sample is held in a pending buffer and applied on CS rising edge, so a burst read is always coherent.
  - If a second strobe arrives while pending, the newer sample wins.
- CS rising mid-byte: the partial byte is discarded (no write), miso_oe drops the next cycle, and the state returns to IDLE.
- xfer_done pulses on CS rise only if at least one full byte (including the command) completed.
- Reset mid-transaction: registers return to reset values and the transaction is abandoned via WAIT_CS.
- CS low with no spi_clk edges produces no register effects.

Decomposition:
- adxl345_pkg:
  - Register address constants: ADDR_DEVID, ADDR_BW_RATE, ADDR_POWER_CTL, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1.
  - Reset values.
  - Responder state enum (IDLE, CMD, DATA, WAIT_CS).
- The package is shared with the SPI master so both ends use identical addresses.
- Sub-module spi_edge_sync: synchronizer plus rise/fall pulse generation for CS and spi_clk, and MOSI alignment.

Test Plan:
- Read DEVID: command 0x80, one dummy byte -> MISO returns 0xE5; miso_oe high only during the data byte.
- Write power_ctl: command 0x2D, data 0x08 -> power_ctl=0x08 after byte 8. A subsequent read of 0x2D returns 0x08.
- Multi-byte read:
  - Setup: sample_valid with x=0x1234, y=0xFFF0, z=0x0100, CS high.
  - Stimulus: command 0xF2 plus six dummy bytes.
  - Response: MISO returns 34 12 F0 FF 00 01, then xfer_done pulses.
- Coherency:
  - Setup: during the burst above, strobe sample_valid with x=0xAAAA.
  - Response: the current burst still returns 34 12. The next burst returns AA AA.
- Abort and read-only:
  - Stimulus: command 0x31, then CS raised after 5 data bits.
  - Response: data_format stays 0x00, with no xfer_done for the partial byte.
  - Stimulus: write 0x55 to 0x00.
  - Response: DEVID still reads 0xE5.
- Reset mid-burst:
  - Stimulus: assert reset during DATA, release while CS is low, keep clocking.
  - Response: no MISO drive and no writes until CS toggles high then low. Registers are at reset values.
